dma_ctrl: RTL and testbench
===========================

# dma_ctrl

Single-channel DMA transfer engine directly upstream of `mem_bus`. On a start command it walks a block of `xfer_len` bytes from the TX ROM starting at `src_addr` and copies it into the RX memory starting at `dst_addr`. It generates `tx_mem_addr`, `rx_mem_addr`, `mem_wr_en` and `data_rx_in` for `mem_bus`, and consumes `data_tx_out` from it. Each byte takes one read cycle and one write cycle.

## Interface
- `WIDTH`, default 8: data width, address width, length width and count width.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  transfer request; sampled only in IDLE.
- `src_addr`  in  WIDTH  TX ROM base address; latched on accepted `start`.
- `dst_addr`  in  WIDTH  RX memory base address; latched on accepted `start`.
- `xfer_len`  in  WIDTH  byte count, 0..2^WIDTH-1; latched on accepted `start`.
- `data_tx_out`  in  WIDTH  combinational TX ROM read data for the current `tx_mem_addr`.
- `tx_mem_addr`  out  WIDTH  TX ROM read address (registered).
- `rx_mem_addr`  out  WIDTH  RX memory write address (registered).
- `data_rx_in`  out  WIDTH  RX memory write data (registered).
- `mem_wr_en`  out  1  RX write strobe; high exactly in WRITE.
- `busy`  out  1  high in READ and WRITE.
- `done`  out  1  one-cycle pulse in DONE.
- `xfer_cnt`  out  WIDTH  bytes written in the current or last transfer.
- `abort`  in  1  present only with `DMA_ABORT_EN` (see Configuration).

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - If `start`=1: latch the bases and length, clear `xfer_cnt`.
  - If `xfer_len`=0, go to DONE; otherwise load `tx_mem_addr`←`src_addr` and `rx_mem_addr`←`dst_addr`, then go to READ.
  - `start`=0 stays in IDLE.
- READ: `tx_mem_addr` is stable for the whole cycle. At the edge, `data_rx_in`←`data_tx_out`, then go to WRITE.
- WRITE: `mem_wr_en`=1; RX memory captures `data_rx_in` at `rx_mem_addr` on this edge. At the same edge:
  - `xfer_cnt`+1.
  - If `xfer_cnt`+1 equals the latched length, go to DONE.
  - Otherwise `tx_mem_addr`+1, `rx_mem_addr`+1, go to READ.
- DONE: `done`=1 for one cycle, then unconditionally go to IDLE. `xfer_cnt` holds its value until the next accepted start.
- Address arithmetic is modulo 2^WIDTH: 8'hFF+1 wraps to 8'h00, independently for source and destination.
- `start` is ignored in READ, WRITE and DONE; no queuing.
- A length of 2^WIDTH cannot be expressed; the maximum transfer is 2^WIDTH-1 bytes.
- Input changes on `src_addr`, `dst_addr` or `xfer_len` after start is accepted have no effect on the transfer in progress.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE; `tx_mem_addr`, `rx_mem_addr`, `data_rx_in` and `xfer_cnt` are 0; `mem_wr_en`, `busy` and `done` are 0.
- Reset mid-transfer kills the transfer immediately. Writes that completed before reset remain in RX memory, and no `done` pulse is produced.
- `start` accepted at edge k (N>0):
  - READ in cycle k+1; first write at edge k+2.
  - Byte i is written at edge k+2+2i.
  - DONE in cycle k+2N+1; back in IDLE at k+2N+2.
  - The next `start` can be accepted at edge k+2N+2.
- `start` accepted at edge k with N=0: DONE in cycle k+1, no `mem_wr_en`.
- Throughput is one byte per 2 clocks.
- `mem_wr_en` and `busy` decode the state register only, so they are glitch-free with respect to inputs.

## Configuration
- `DMA_ABORT_EN` defined:
  - The `abort` input exists. `abort`=1 sampled in READ goes to DONE without writing.
  - `abort`=1 sampled in WRITE lets that write complete (`xfer_cnt` increments), then goes to DONE.
  - `abort` in IDLE or DONE is ignored.
  - `xfer_cnt` at `done` reports the bytes actually written.
- `DMA_ABORT_EN` undefined: no `abort` port; every accepted transfer runs to `xfer_len` bytes.

## Test plan
- Reset mid-transfer: `rst` low at N=5, byte 2 → all outputs 0 immediately, IDLE. RX holds bytes 0–1 only, and no `done` pulse.
- Basic copy: src=8'h10, dst=8'h40, len=4 → RX[40..43]=ROM[10..13]; four `mem_wr_en` pulses every 2 cycles; `done` in cycle k+9; `xfer_cnt`=4.
- Zero length: len=0 → `done` in cycle k+1; no `mem_wr_en`; `xfer_cnt`=0.
- Wrap-around: src=8'hFE, dst=8'hFF, len=3 → reads FE, FF, 00; writes FF, 00, 01; `xfer_cnt`=3.
- Start while busy: second `start` with different bases during a len=2 transfer → ignored. Only the first transfer's 2 writes occur, and the new bases take effect only after IDLE.
- `DMA_ABORT_EN` abort: len=8, `abort` in the third WRITE cycle → exactly 3 writes, then `done`, with `xfer_cnt`=3. Abort in READ of byte 0 → 0 writes, `done` next cycle.

Source files
------------

// File: rtl/dma_ctrl.sv
// dma_ctrl: single-channel DMA copy engine feeding mem_bus.
// Reads one byte from the TX ROM, writes it into RX memory on the next cycle,
// and walks both addresses (mod 2^WIDTH) until the latched length is reached.
// Optional feature macro: DMA_ABORT_EN adds an `abort` input that ends the
// transfer early (a write already in flight still completes).
module dma_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src_addr,
    input  logic [WIDTH-1:0] dst_addr,
    input  logic [WIDTH-1:0] xfer_len,
    input  logic [WIDTH-1:0] data_tx_out,
`ifdef DMA_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] tx_mem_addr,
    output logic [WIDTH-1:0] rx_mem_addr,
    output logic [WIDTH-1:0] data_rx_in,
    output logic             mem_wr_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] tx_addr_q;
    logic [WIDTH-1:0] rx_addr_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] len_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             abort_s;

`ifdef DMA_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Byte count after the write happening in the current WRITE cycle.
    assign cnt_d = cnt_q + 1'b1;

    // Transfer sequencer: latches the command, walks addresses, counts writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            tx_addr_q <= '0;
            rx_addr_q <= '0;
            data_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q <= xfer_len;
                        cnt_q <= '0;
                        if (xfer_len == '0) begin
                            state_q <= DONE;
                        end else begin
                            tx_addr_q <= src_addr;
                            rx_addr_q <= dst_addr;
                            state_q   <= READ;
                        end
                    end
                end
                READ: begin
                    // An abort here means this byte is never written.
                    if (abort_s) begin
                        state_q <= DONE;
                    end else begin
                        data_q  <= data_tx_out;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    // The write strobed this cycle always lands, so it is counted.
                    cnt_q <= cnt_d;
                    if (cnt_d == len_q || abort_s) begin
                        state_q <= DONE;
                    end else begin
                        tx_addr_q <= tx_addr_q + 1'b1;
                        rx_addr_q <= rx_addr_q + 1'b1;
                        state_q   <= READ;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes decode the state register only, so they never glitch on inputs.
    assign mem_wr_en   = (state_q == WRITE);
    assign busy        = (state_q == READ) || (state_q == WRITE);
    assign done        = (state_q == DONE);
    assign tx_mem_addr = tx_addr_q;
    assign rx_mem_addr = rx_addr_q;
    assign data_rx_in  = data_q;
    assign xfer_cnt    = cnt_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// Bench for dma_ctrl: ROM/RX memories modelled here, transfers checked against
// a simple copy model (expected write list, timing, and RX memory image).
module tb_dma_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] src_addr, dst_addr, xfer_len, data_tx_out;
    logic [7:0] tx_mem_addr, rx_mem_addr, data_rx_in, xfer_cnt;
    logic       mem_wr_en, busy, done;
`ifdef DMA_ABORT_EN
    logic       abort;
`endif

    dma_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .xfer_len(xfer_len),
        .data_tx_out(data_tx_out),
`ifdef DMA_ABORT_EN
        .abort(abort),
`endif
        .tx_mem_addr(tx_mem_addr), .rx_mem_addr(rx_mem_addr),
        .data_rx_in(data_rx_in), .mem_wr_en(mem_wr_en), .busy(busy),
        .done(done), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [256];
    logic [7:0] rx_mem [256];
    logic [7:0] exp_rx [256];
    assign data_tx_out = rom[tx_mem_addr];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int wr_a[$];
    int wr_d[$];
    int wr_c[$];

    // Memory side of mem_bus plus an edge counter and a write log.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst && mem_wr_en) begin
            rx_mem[rx_mem_addr] = data_rx_in;
            wr_a.push_back(int'(rx_mem_addr));
            wr_d.push_back(int'(data_rx_in));
            wr_c.push_back(cyc);
        end
        if (rst && done) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    // Issue a start at the next negedge; k returns the accepting edge number.
    task automatic do_start(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            output int k);
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; xfer_len = l;
        wr_a.delete(); wr_d.delete(); wr_c.delete();
        for (int i = 0; i < 256; i++) exp_rx[i] = rx_mem[i];
        @(negedge clk);
        k = cyc;
        start = 1'b0;
        // Scramble command inputs: the transfer in flight must not see them.
        src_addr = 8'($urandom); dst_addr = 8'($urandom); xfer_len = 8'($urandom);
    endtask

    // Expected result: n bytes copied src+i -> dst+i, byte i written at edge k+2+2i.
    task automatic verify(input string nm, input logic [7:0] s, input logic [7:0] d,
                          input int n, input int k, input int lat);
        int at = 0;
        bit seen = 0;
        int bad = 0;
        logic [7:0] sa, da;
        for (int c = 0; c < 2 * n + 8 && !seen; c++) begin
            if (done) begin seen = 1; at = cyc; end
            else @(negedge clk);
        end
        chk({nm, "_done_seen"}, int'(seen), 1);
        if (seen) chk({nm, "_done_lat"}, at - k, lat);
        @(negedge clk);
        chk({nm, "_done_pulse"}, int'(done), 0);
        chk({nm, "_cnt"}, int'(xfer_cnt), n);
        chk({nm, "_nwr"}, wr_a.size(), n);
        for (int i = 0; i < n; i++) begin
            sa = s + 8'(i);
            da = d + 8'(i);
            exp_rx[da] = rom[sa];
            if (i < wr_a.size()) begin
                if (wr_a[i] != int'(da) || wr_d[i] != int'(rom[sa]) || wr_c[i] != k + 2 + 2 * i)
                    bad++;
            end
        end
        chk({nm, "_wr_seq"}, bad, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (rx_mem[i] !== exp_rx[i]) bad++;
        chk({nm, "_rx_mem"}, bad, 0);
    endtask

    typedef struct {
        string      nm;
        logic [7:0] s, d, l;
        int         exp_cnt;
        int         exp_lat;
    } vec_t;

    vec_t vecs [5];
    int   k, base;

    initial begin
        vecs[0] = '{"basic",  8'h10, 8'h40, 8'd4,   4,   8};
        vecs[1] = '{"zero",   8'h20, 8'h30, 8'd0,   0,   0};
        vecs[2] = '{"wrap",   8'hFE, 8'hFF, 8'd3,   3,   6};
        vecs[3] = '{"single", 8'h80, 8'h00, 8'd1,   1,   2};
        vecs[4] = '{"max",    8'h05, 8'h90, 8'd255, 255, 510};
        for (int i = 0; i < 256; i++) begin rom[i] = 8'($urandom); rx_mem[i] = 8'h00; end

        rst = 1'b0; start = 1'b0; src_addr = 8'h0; dst_addr = 8'h0; xfer_len = 8'h0;
`ifdef DMA_ABORT_EN
        abort = 1'b0;
`endif
        #1;
        chk("reset_outs", int'({tx_mem_addr, rx_mem_addr, data_rx_in, xfer_cnt}), 0);
        chk("reset_flags", int'({mem_wr_en, busy, done}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        foreach (vecs[i]) begin
            do_start(vecs[i].s, vecs[i].d, vecs[i].l, k);
            chk({vecs[i].nm, "_busy"}, int'(busy), int'(vecs[i].exp_cnt > 0));
            verify(vecs[i].nm, vecs[i].s, vecs[i].d, vecs[i].exp_cnt, k, vecs[i].exp_lat);
        end

        // Start pulses while busy are dropped; new bases apply only from IDLE.
        do_start(8'h50, 8'h60, 8'd2, k);
        start = 1'b1; src_addr = 8'hA0; dst_addr = 8'hB0; xfer_len = 8'd7;
        repeat (3) @(negedge clk);
        start = 1'b0;
        verify("busy_start", 8'h50, 8'h60, 2, k, 4);
        do_start(8'hA0, 8'hB0, 8'd2, k);
        verify("after_busy", 8'hA0, 8'hB0, 2, k, 4);

        // Reset during byte 2 of a 5-byte copy.
        do_start(8'h30, 8'h70, 8'd5, k);
        repeat (4) @(negedge clk);
        base = done_cnt;
        rst = 1'b0;
        #1;
        chk("midrst_outs", int'({tx_mem_addr, rx_mem_addr, data_rx_in, xfer_cnt}), 0);
        chk("midrst_flags", int'({mem_wr_en, busy, done}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_no_done", done_cnt - base, 0);
        chk("midrst_nwr", wr_a.size(), 2);
        for (int i = 0; i < 2; i++) exp_rx[8'h70 + 8'(i)] = rom[8'h30 + 8'(i)];
        base = 0;
        for (int i = 0; i < 256; i++) if (rx_mem[i] !== exp_rx[i]) base++;
        chk("midrst_rx_mem", base, 0);

`ifdef DMA_ABORT_EN
        // Abort in the third WRITE: that write lands, then DONE.
        do_start(8'h00, 8'hC0, 8'd8, k);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        verify("abort_wr", 8'h00, 8'hC0, 3, k, 6);
        // Abort in READ of byte 0: nothing written.
        do_start(8'h10, 8'hD0, 8'd8, k);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        verify("abort_rd", 8'h10, 8'hD0, 0, k, 1);
`endif

        // Random transfers against the copy model.
        for (int t = 0; t < 20; t++) begin
            logic [7:0] s, d, l;
            s = 8'($urandom); d = 8'($urandom); l = 8'($urandom_range(0, 20));
            do_start(s, d, l, k);
            verify($sformatf("rand%0d", t), s, d, int'(l), k, 2 * int'(l));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
